// File: rtl/ultrasonic_echo_timer.sv
// Ultrasonic ranger controller: periodic trigger pulse, synchronized echo capture,
// echo high width reported in clk cycles with timeout on a missing or overlong echo.
module ultrasonic_echo_timer #(
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int PERIOD_CYCLES  = 3000000
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        echo,
  output logic        trigger,
  output logic [31:0] read_data,
  output logic        read_data_valid,
  output logic        timeout
);

  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] PER_LAST  = 32'(PERIOD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  state_t      state, state_n;
  logic        echo_m, echo_s, echo_d;
  logic        idle_done;
  logic [31:0] pcnt, wcnt;
  logic        rise, fall, cap, to;

  assign rise = echo_s & ~echo_d;
  assign fall = ~echo_s & echo_d;

  // Edge-based rise detection means an echo already high on entry to
  // WAIT_RISE is ignored until it drops and rises again.
  always_comb begin
    state_n = state;
    cap     = 1'b0;
    to      = 1'b0;
    case (state)
      IDLE:      if (idle_done) state_n = TRIG;
      TRIG:      if (pcnt == TRIG_LAST) state_n = WAIT_RISE;
      WAIT_RISE: begin
        if (rise) state_n = MEASURE;
        else if (wcnt == TO_LAST) begin
          to      = 1'b1;
          state_n = HOLDOFF;
        end
      end
      MEASURE: begin
        if (fall) begin
          cap     = 1'b1;
          state_n = HOLDOFF;
        end else if (wcnt == TO_LAST) begin
          to      = 1'b1;
          state_n = HOLDOFF;
        end
      end
      HOLDOFF:   if (pcnt == PER_LAST) state_n = TRIG;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state           <= IDLE;
      echo_m          <= 1'b0;
      echo_s          <= 1'b0;
      echo_d          <= 1'b0;
      idle_done       <= 1'b0;
      pcnt            <= '0;
      wcnt            <= '0;
      trigger         <= 1'b0;
      timeout         <= 1'b0;
      read_data       <= '0;
      read_data_valid <= 1'b0;
    end else begin
      echo_m    <= echo;
      echo_s    <= echo_m;
      echo_d    <= echo_s;
      idle_done <= 1'b1;
      state     <= state_n;
      trigger   <= (state_n == TRIG);
      timeout   <= to;
      pcnt      <= (state_n == TRIG && state != TRIG) ? '0 : pcnt + 32'd1;
      // The rise cycle is itself the first high cycle, so MEASURE starts at 1.
      if (state_n == WAIT_RISE && state != WAIT_RISE)  wcnt <= '0;
      else if (state_n == MEASURE && state != MEASURE) wcnt <= 32'd1;
      else                                             wcnt <= wcnt + 32'd1;
      if (cap) begin
        read_data       <= wcnt;
        read_data_valid <= 1'b1;
      end else if (to) begin
        read_data_valid <= 1'b0;
      end
    end
  end

endmodule
